// File: rtl/dpwm_loop_sequencer_if.sv
// Purpose : Bundles the loop sequencer's control, ADC handshake, encoder
//           and DPWM duty signals into one interface.
// Signals : enable, period_start, adc_done, err_code[3:0], clr_flags
//           (towards the sequencer); adc_start, duty[DUTY_W-1:0],
//           duty_load, adc_timeout, overrun (from the sequencer).
// Modports: master - drives the sequencer inputs (DPWM/ADC/encoder side)
//           slave  - the sequencer itself
interface dpwm_loop_sequencer_if #(
    parameter int DUTY_W = 8
);
    logic              enable;
    logic              period_start;
    logic              adc_done;
    logic [3:0]        err_code;
    logic              clr_flags;
    logic              adc_start;
    logic [DUTY_W-1:0] duty;
    logic              duty_load;
    logic              adc_timeout;
    logic              overrun;

    modport master (
        output enable, period_start, adc_done, err_code, clr_flags,
        input  adc_start, duty, duty_load, adc_timeout, overrun
    );

    modport slave (
        input  enable, period_start, adc_done, err_code, clr_flags,
        output adc_start, duty, duty_load, adc_timeout, overrun
    );
endinterface

// File: rtl/dpwm_loop_sequencer.sv
// Purpose : Per-switching-period sequencer for the digital voltage loop.
//           Times the ADC trigger after each DPWM period boundary, waits for
//           the conversion, integrates the encoder error into a clamped duty
//           command and hands it to the DPWM on the next boundary.
// Ports   : i_clk    - system clock
//           i_rst_n  - asynchronous active-low reset
//           io_bus   - dpwm_loop_sequencer_if.slave (enable, period_start,
//                      adc_done, err_code, clr_flags in; adc_start, duty,
//                      duty_load, adc_timeout, overrun out)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | loop parked, waiting for enable & period_start
// DELAY  | counting SAMPLE_DLY cycles from the period boundary
// TRIG   | adc_start high for this single cycle
// WAIT   | waiting for adc_done, bounded by ADC_TIMEOUT
// SETTLE | one cycle for the encoder output register
// CALC   | integrate err_code into duty_cmd with clamping
// HOLD   | duty_cmd ready, loaded to the DPWM on period_start
module dpwm_loop_sequencer #(
    parameter int DUTY_W      = 8,
    parameter int DUTY_INIT   = 128,
    parameter int DUTY_MIN    = 16,
    parameter int DUTY_MAX    = 232,
    parameter int KI_SHIFT    = 0,
    parameter int SAMPLE_DLY  = 4,
    parameter int ADC_TIMEOUT = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    dpwm_loop_sequencer_if.slave  io_bus
);
    localparam int SUM_W   = DUTY_W + 2;
    localparam int CNT_MAX = (SAMPLE_DLY > ADC_TIMEOUT) ? SAMPLE_DLY : ADC_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Down-counters are loaded with N-1 so the terminal count (zero) is the
    // Nth cycle spent in the state.
    localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(SAMPLE_DLY - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(ADC_TIMEOUT - 1);

    localparam logic signed [SUM_W-1:0] C_MIN = SUM_W'(DUTY_MIN);
    localparam logic signed [SUM_W-1:0] C_MAX = SUM_W'(DUTY_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_DELAY, S_TRIG, S_WAIT, S_SETTLE, S_CALC, S_HOLD
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DUTY_W-1:0]   r_duty;
    logic [DUTY_W-1:0]   r_duty_cmd;
    logic                r_adc_start;
    logic                r_duty_load;
    logic                r_adc_timeout;
    logic                r_overrun;

    logic signed [SUM_W-1:0] w_err_ext;
    logic signed [SUM_W-1:0] w_sum;
    logic [DUTY_W-1:0]       w_duty_next;
    logic                    w_busy;

    // Integration is done two bits wider than the duty so both an underflow
    // below zero and an overflow past full scale are seen by the clamp.
    always_comb begin
        w_err_ext   = {{(SUM_W-4){io_bus.err_code[3]}}, io_bus.err_code};
        w_sum       = $signed({2'b00, r_duty_cmd}) + (w_err_ext <<< KI_SHIFT);
        w_duty_next = w_sum[DUTY_W-1:0];
        if (w_sum < C_MIN) begin
            w_duty_next = DUTY_W'(DUTY_MIN);
        end else if (w_sum > C_MAX) begin
            w_duty_next = DUTY_W'(DUTY_MAX);
        end
    end

    // A boundary arriving before HOLD (including the CALC cycle) is an overrun.
    assign w_busy = (r_state == S_DELAY) || (r_state == S_TRIG) ||
                    (r_state == S_WAIT)  || (r_state == S_SETTLE) ||
                    (r_state == S_CALC);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_duty        <= DUTY_W'(DUTY_INIT);
            r_duty_cmd    <= DUTY_W'(DUTY_INIT);
            r_adc_start   <= 1'b0;
            r_duty_load   <= 1'b0;
            r_adc_timeout <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_adc_start <= 1'b0;
            r_duty_load <= 1'b0;

            // Clear first; any set below overrides it in the same cycle.
            if (io_bus.clr_flags) begin
                r_adc_timeout <= 1'b0;
                r_overrun     <= 1'b0;
            end

            if (!io_bus.enable) begin
                // In-flight sample is dropped; duty and duty_cmd keep their value.
                r_state <= S_IDLE;
            end else begin
                if (io_bus.period_start && w_busy) begin
                    r_overrun <= 1'b1;
                end

                case (r_state)
                    S_IDLE: begin
                        if (io_bus.period_start) begin
                            r_state <= S_DELAY;
                            r_cnt   <= DLY_LOAD;
                        end
                    end
                    S_DELAY: begin
                        if (r_cnt == '0) begin
                            r_state     <= S_TRIG;
                            r_adc_start <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_TRIG: begin
                        r_state <= S_WAIT;
                        r_cnt   <= TMO_LOAD;
                    end
                    S_WAIT: begin
                        if (io_bus.adc_done) begin
                            r_state <= S_SETTLE;
                        end else if (r_cnt == '0) begin
                            r_adc_timeout <= 1'b1;
                            r_state       <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        r_state <= S_CALC;
                    end
                    S_CALC: begin
                        r_duty_cmd <= w_duty_next;
                        r_state    <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (io_bus.period_start) begin
                            r_duty      <= r_duty_cmd;
                            r_duty_load <= 1'b1;
                            r_state     <= S_DELAY;
                            r_cnt       <= DLY_LOAD;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign io_bus.adc_start   = r_adc_start;
    assign io_bus.duty        = r_duty;
    assign io_bus.duty_load   = r_duty_load;
    assign io_bus.adc_timeout = r_adc_timeout;
    assign io_bus.overrun     = r_overrun;
endmodule

// File: tb/tb_dpwm_loop_sequencer.sv
// Purpose : Directed bench for dpwm_loop_sequencer. One default instance
//           runs the full timeline; three extra instances (high clamp, low
//           clamp, KI_SHIFT=2) see the same control stimulus with their own
//           error codes.
module tb_dpwm_loop_sequencer;
    logic clk;
    logic rst_n;
    logic en, ps, done, clr;
    logic [3:0] err_main, err_hi, err_lo, err_ki;

    int n_checks = 0;
    int n_errors = 0;

    dpwm_loop_sequencer_if #(.DUTY_W(8)) u_if_main ();
    dpwm_loop_sequencer_if #(.DUTY_W(8)) u_if_hi ();
    dpwm_loop_sequencer_if #(.DUTY_W(8)) u_if_lo ();
    dpwm_loop_sequencer_if #(.DUTY_W(8)) u_if_ki ();

    assign u_if_main.enable = en;  assign u_if_main.period_start = ps;
    assign u_if_main.adc_done = done; assign u_if_main.clr_flags = clr;
    assign u_if_main.err_code = err_main;
    assign u_if_hi.enable = en;    assign u_if_hi.period_start = ps;
    assign u_if_hi.adc_done = done; assign u_if_hi.clr_flags = clr;
    assign u_if_hi.err_code = err_hi;
    assign u_if_lo.enable = en;    assign u_if_lo.period_start = ps;
    assign u_if_lo.adc_done = done; assign u_if_lo.clr_flags = clr;
    assign u_if_lo.err_code = err_lo;
    assign u_if_ki.enable = en;    assign u_if_ki.period_start = ps;
    assign u_if_ki.adc_done = done; assign u_if_ki.clr_flags = clr;
    assign u_if_ki.err_code = err_ki;

    dpwm_loop_sequencer u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .io_bus(u_if_main)
    );
    dpwm_loop_sequencer #(.DUTY_INIT(230)) u_dut_hi (
        .i_clk(clk), .i_rst_n(rst_n), .io_bus(u_if_hi)
    );
    dpwm_loop_sequencer #(.DUTY_INIT(17)) u_dut_lo (
        .i_clk(clk), .i_rst_n(rst_n), .io_bus(u_if_lo)
    );
    dpwm_loop_sequencer #(.KI_SHIFT(2)) u_dut_ki (
        .i_clk(clk), .i_rst_n(rst_n), .io_bus(u_if_ki)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int starts;
        rst_n = 1'b0;
        en = 1'b0; ps = 1'b0; done = 1'b0; clr = 1'b0;
        err_main = 4'b0100;
        err_hi   = 4'b0100;
        err_lo   = 4'b1100;
        err_ki   = 4'b1111;

        tick();
        tick();
        chk("rst_duty",      32'(u_if_main.duty), 32'd128);
        chk("rst_adc_start", 32'(u_if_main.adc_start), 32'd0);
        chk("rst_duty_load", 32'(u_if_main.duty_load), 32'd0);
        chk("rst_timeout",   32'(u_if_main.adc_timeout), 32'd0);
        chk("rst_overrun",   32'(u_if_main.overrun), 32'd0);
        chk("rst_duty_hi",   32'(u_if_hi.duty), 32'd230);
        chk("rst_duty_lo",   32'(u_if_lo.duty), 32'd17);

        // Boundary with the loop disabled must not start anything.
        rst_n = 1'b1;
        ps = 1'b1;
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            ps = 1'b0;
            if (u_if_main.adc_start) starts++;
        end
        chk("idle_no_start", 32'(starts), 32'd0);

        // Cycle 0: enable and first period boundary.
        en = 1'b1;
        ps = 1'b1;
        for (int c = 1; c <= 138; c++) begin
            tick();
            ps   = (c inside {15, 24, 31, 41, 103, 115, 118, 133});
            done = (c inside {10, 26, 112, 128});
            clr  = (c inside {41, 42, 110});
            en   = !(c >= 113 && c <= 115);

            chk($sformatf("adc_start@%0d", c), 32'(u_if_main.adc_start),
                32'((c inside {5, 20, 36, 108, 123, 138}) ? 1 : 0));
            chk($sformatf("duty_load@%0d", c), 32'(u_if_main.duty_load),
                32'((c inside {16, 32, 134}) ? 1 : 0));
            chk($sformatf("duty@%0d", c), 32'(u_if_main.duty),
                (c < 16) ? 32'd128 : (c < 32) ? 32'd132 : (c < 134) ? 32'd136 : 32'd140);
            chk($sformatf("overrun@%0d", c), 32'(u_if_main.overrun),
                32'((c >= 25 && c <= 42) ? 1 : 0));
            chk($sformatf("adc_timeout@%0d", c), 32'(u_if_main.adc_timeout),
                32'((c >= 101 && c <= 110) ? 1 : 0));

            if (c == 16) begin
                chk("clamp_hi_first",  32'(u_if_hi.duty), 32'd232);
                chk("clamp_lo_first",  32'(u_if_lo.duty), 32'd16);
                chk("ki_shift2_first", 32'(u_if_ki.duty), 32'd124);
            end
            if (c == 33) begin
                chk("clamp_hi_second",  32'(u_if_hi.duty), 32'd232);
                chk("clamp_lo_second",  32'(u_if_lo.duty), 32'd16);
                chk("ki_shift2_second", 32'(u_if_ki.duty), 32'd120);
            end
        end

        // Asynchronous reset while adc_start is high.
        rst_n = 1'b0;
        #2;
        chk("arst_duty",      32'(u_if_main.duty), 32'd128);
        chk("arst_adc_start", 32'(u_if_main.adc_start), 32'd0);
        chk("arst_duty_load", 32'(u_if_main.duty_load), 32'd0);
        chk("arst_timeout",   32'(u_if_main.adc_timeout), 32'd0);
        chk("arst_overrun",   32'(u_if_main.overrun), 32'd0);
        chk("arst_duty_ki",   32'(u_if_ki.duty), 32'd128);

        tick();
        rst_n = 1'b1;
        ps = 1'b0;
        done = 1'b0;
        clr = 1'b0;
        en = 1'b1;
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (u_if_main.adc_start) starts++;
        end
        chk("post_rst_no_start", 32'(starts), 32'd0);
        chk("post_rst_duty",     32'(u_if_main.duty), 32'd128);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
